// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
// IJTAG TDR plus hold/ack handshake FSM that owns select and IJTAG data of the gate1 data mux.
// Optional macro FIREBIRD7_DATA_MUX_SEQ_TIMEOUT_EN adds the HOLD timeout and sticky timeout_err.
module firebird7_in_gate1_tessent_data_mux_seq #(
  parameter int WIDTH   = 19,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] observe_data,
  input  logic             func_hold_ack,
  output logic             func_hold_req,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_in
);

`ifdef FIREBIRD7_DATA_MUX_SEQ_TIMEOUT_EN
  localparam int CW = 16;
`else
  localparam int CW = 8;
`endif

  typedef enum logic [2:0] {FUNC, HOLD, ARM, OVERRIDE, RELEASE} state_e;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               select_q, hold_q;
  logic [WIDTH+1:0]   sr_q;
  logic [WIDTH-1:0]   data_q;
  logic               en_q, start_q;
  logic               timeout_err_q;
  logic               cap, shf, upd, tmo_hit;

  // One TDR operation per cycle: capture beats shift beats update.
  assign cap = ijtag_sel & ijtag_ce;
  assign shf = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign upd = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;

  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      sr_q    <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (cap) begin
        sr_q <= {observe_data, timeout_err_q, state_q == OVERRIDE};
      end else if (shf) begin
        sr_q <= {ijtag_si, sr_q[WIDTH+1:1]};
      end else if (upd) begin
        data_q  <= sr_q[WIDTH+1:2];
        en_q    <= sr_q[0];
        // Only a fresh update arms the sequence; a stale en_q never does.
        start_q <= sr_q[0] && (state_q == FUNC);
      end
    end
  end

`ifdef FIREBIRD7_DATA_MUX_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  assign tmo_hit = (state_q == HOLD) && !func_hold_ack && en_q && (cnt_q == TMO_LAST);

  // A timeout landing on the same edge as an err_clr update keeps the flag set.
  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset)       timeout_err_q <= 1'b0;
    else if (tmo_hit)       timeout_err_q <= 1'b1;
    else if (upd && sr_q[1]) timeout_err_q <= 1'b0;
  end
`else
  assign tmo_hit       = 1'b0;
  assign timeout_err_q = 1'b0;
`endif

  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      state_q  <= FUNC;
      cnt_q    <= '0;
      select_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      case (state_q)
        FUNC: begin
          cnt_q <= '0;
          if (start_q) begin
            state_q <= HOLD;
            hold_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (func_hold_ack) begin
            state_q  <= ARM;
            select_q <= 1'b1;
            cnt_q    <= '0;
          end else if (!en_q || tmo_hit) begin
            state_q <= FUNC;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
`ifdef FIREBIRD7_DATA_MUX_SEQ_TIMEOUT_EN
            cnt_q <= cnt_q + CW'(1);
`else
            cnt_q <= '0;
`endif
          end
        end
        ARM: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= OVERRIDE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        OVERRIDE: begin
          // Ack is deliberately ignored here: the hold is ours until RELEASE ends.
          cnt_q <= '0;
          if (!en_q) begin
            state_q  <= RELEASE;
            select_q <= 1'b0;
          end
        end
        RELEASE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= FUNC;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= FUNC;
          cnt_q    <= '0;
          select_q <= 1'b0;
          hold_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ijtag_so      = sr_q[0];
  assign ijtag_data_in = data_q;
  assign ijtag_select  = select_q;
  assign func_hold_req = hold_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_seq.sv
// Directed/randomized bench for the gate1 data mux sequencer; expectations come from the
// handshake timing rules (update->req N+2, ack->select A+1, release U+2 / U+2+SETTLE).
module tb_firebird7_in_gate1_tessent_data_mux_seq;
  localparam int W       = 19;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  logic         tck = 1'b0, rst_n = 1'b0;
  logic         sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0, ack = 1'b0;
  logic [W-1:0] obs = '0;
  logic         so, hreq, isel;
  logic [W-1:0] din;
  int           tests = 0, fails = 0;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_mux_seq #(.WIDTH(W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_ce(ce), .ijtag_se(se),
    .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so), .observe_data(obs), .func_hold_ack(ack),
    .func_hold_req(hreq), .ijtag_select(isel), .ijtag_data_in(din)
  );

  // Sticky observers for "never rises" style checks.
  logic sel_seen = 1'b0, req_seen = 1'b0;
  always @(negedge tck) begin
    if (isel) sel_seen = 1'b1;
    if (hreq) req_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge tck); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Optional capture, full-length shift (LSB first), optional update; returns shifted-out word.
  task automatic scan(input bit cap, input logic [W+1:0] sin, input bit upd,
                      output logic [W+1:0] sout);
    sel = 1'b1;
    if (cap) begin ce = 1'b1; tick(); ce = 1'b0; end
    se = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      sout[i] = so;
      si = sin[i];
      tick();
    end
    se = 1'b0; si = 1'b0;
    if (upd) begin ue = 1'b1; tick(); ue = 1'b0; end
    sel = 1'b0;
  endtask

  logic [W+1:0] sout;
  logic [W-1:0] data, data2;
  int           dly;
  bit           lost;

  initial begin
    // Reset with all enables low.
    tick(); tick();
    chk("rst_select", 64'(isel), 64'd0);
    chk("rst_hreq",   64'(hreq), 64'd0);
    chk("rst_din",    64'(din),  64'd0);
    chk("rst_so",     64'(so),   64'd0);
    rst_n = 1'b1;
    tick();

    // Idle capture: {observe, err=0, ovr=0}.
    for (int k = 0; k < 3; k++) begin
      obs = W'($urandom);
      scan(1'b1, '0, 1'b0, sout);
      chk("cap_idle", 64'(sout), 64'({obs, 1'b0, 1'b0}));
    end

    // Full override / release handshakes.
    for (int it = 0; it < 3; it++) begin
      data = (it == 0) ? 19'h5A5A5 : W'($urandom);
      dly  = (it == 0) ? 3 : $urandom_range(1, 6);
      ack  = 1'b0;
      scan(1'b0, {data, 1'b0, 1'b1}, 1'b1, sout);   // now in N+1
      chk("start_lat_hreq", 64'(hreq), 64'd0);
      chk("upd_din", 64'(din), 64'(data));
      tick();                                        // N+2
      chk("hreq_rise", 64'(hreq), 64'd1);
      for (int c = 0; c < dly; c++) begin
        chk("sel_before_ack", 64'(isel), 64'd0);
        tick();
      end
      ack = 1'b1;                                    // cycle A
      chk("sel_at_ack", 64'(isel), 64'd0);
      tick();                                        // A+1
      chk("sel_rise", 64'(isel), 64'd1);
      chk("ovr_din", 64'(din), 64'(data));
      ack = 1'($urandom_range(0, 1));                // dropping ack must be ignored
      for (int c = 0; c < SETTLE - 1; c++) tick();   // A+SETTLE, still ARM
      obs = W'($urandom);
      scan(1'b1, '0, 1'b0, sout);
      chk("cap_arm_last", 64'(sout), 64'({obs, 1'b0, 1'b0}));
      obs = W'($urandom);
      scan(1'b1, '0, 1'b0, sout);
      chk("cap_override", 64'(sout), 64'({obs, 1'b0, 1'b1}));
      chk("ovr_sel", 64'(isel), 64'd1);
      chk("ovr_hreq", 64'(hreq), 64'd1);

      data2 = W'($urandom);
      scan(1'b0, {data2, 2'b00}, 1'b1, sout);        // U+1
      chk("rel_u1_sel", 64'(isel), 64'd1);
      chk("rel_din", 64'(din), 64'(data2));
      tick();                                        // U+2
      chk("rel_sel_fall", 64'(isel), 64'd0);
      chk("rel_hreq_hold", 64'(hreq), 64'd1);
      for (int c = 0; c < SETTLE - 1; c++) tick();   // U+1+SETTLE
      chk("rel_settle_hreq", 64'(hreq), 64'd1);
      tick();                                        // U+2+SETTLE
      chk("rel_hreq_fall", 64'(hreq), 64'd0);
      obs = W'($urandom);
      scan(1'b1, '0, 1'b0, sout);
      chk("cap_func", 64'(sout), 64'({obs, 1'b0, 1'b0}));
      ack = 1'b0;
    end

    // Update with override_en=0 from FUNC does nothing.
    req_seen = 1'b0;
    scan(1'b0, {W'($urandom), 2'b00}, 1'b1, sout);
    tick(); tick(); tick();
    chk("noen_idle", 64'(req_seen), 64'd0);

    // Withdrawal in HOLD before ack.
    sel_seen = 1'b0;
    scan(1'b0, {W'($urandom), 2'b01}, 1'b1, sout);
    tick();
    chk("wd_hreq_rise", 64'(hreq), 64'd1);
    dly = $urandom_range(0, 3);
    for (int c = 0; c < dly; c++) tick();
    scan(1'b0, {W'($urandom), 2'b00}, 1'b1, sout);  // W+1
    chk("wd_w1_hreq", 64'(hreq), 64'd1);
    tick();                                          // W+2
    chk("wd_hreq_fall", 64'(hreq), 64'd0);
    ack = 1'b1;
    req_seen = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    ack = 1'b0;
    chk("wd_no_rearm", 64'(req_seen), 64'd0);
    chk("wd_sel_never", 64'(sel_seen), 64'd0);

`ifdef FIREBIRD7_DATA_MUX_SEQ_TIMEOUT_EN
    scan(1'b0, {W'($urandom), 2'b01}, 1'b1, sout);
    tick();                                          // HOLD entry H
    chk("tmo_hreq_rise", 64'(hreq), 64'd1);
    for (int c = 0; c < TIMEOUT - 1; c++) tick();    // H+TIMEOUT-1
    chk("tmo_last_hreq", 64'(hreq), 64'd1);
    tick();                                          // H+TIMEOUT
    chk("tmo_hreq_fall", 64'(hreq), 64'd0);
    obs = W'($urandom);
    scan(1'b1, '0, 1'b0, sout);
    chk("tmo_cap_err", 64'(sout), 64'({obs, 1'b1, 1'b0}));
    req_seen = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("tmo_stale_en", 64'(req_seen), 64'd0);
    scan(1'b0, {W'($urandom), 2'b10}, 1'b1, sout);
    tick();
    obs = W'($urandom);
    scan(1'b1, '0, 1'b0, sout);
    chk("tmo_err_clr", 64'(sout), 64'({obs, 1'b0, 1'b0}));
`else
    scan(1'b0, {W'($urandom), 2'b01}, 1'b1, sout);
    tick();
    chk("notmo_hreq_rise", 64'(hreq), 64'd1);
    lost = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (!hreq) lost = 1'b1;
    end
    chk("notmo_hold", 64'(lost), 64'd0);
    obs = W'($urandom);
    scan(1'b1, {W'($urandom), 2'b11}, 1'b0, sout);
    chk("notmo_cap", 64'(sout), 64'({obs, 1'b0, 1'b0}));
    scan(1'b0, {W'($urandom), 2'b10}, 1'b1, sout);
    tick();
    chk("notmo_withdraw", 64'(hreq), 64'd0);
`endif

    // Reset in OVERRIDE while ack drops on the same edge.
    ack = 1'b0;
    data = W'($urandom);
    scan(1'b0, {data, 2'b01}, 1'b1, sout);
    tick();
    ack = 1'b1;
    tick();                                          // ARM
    for (int c = 0; c < SETTLE; c++) tick();         // OVERRIDE
    scan(1'b0, {data, 2'b01}, 1'b0, sout);           // leaves so=1 before reset
    chk("pre_rst_sel", 64'(isel), 64'd1);
    chk("pre_rst_so", 64'(so), 64'd1);
    rst_n = 1'b0; ack = 1'b0;
    tick();
    chk("mid_rst_sel", 64'(isel), 64'd0);
    chk("mid_rst_hreq", 64'(hreq), 64'd0);
    chk("mid_rst_din", 64'(din), 64'd0);
    chk("mid_rst_so", 64'(so), 64'd0);
    rst_n = 1'b1;
    ack = 1'b1;
    req_seen = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("post_rst_no_rearm", 64'(req_seen), 64'd0);
    ack = 1'b0;
    scan(1'b0, {W'($urandom), 2'b01}, 1'b1, sout);
    tick();
    chk("post_rst_rearm", 64'(hreq), 64'd1);
    scan(1'b0, {W'($urandom), 2'b00}, 1'b1, sout);
    tick();
    chk("post_rst_withdraw", 64'(hreq), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
